// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate-generation stage: upstream instruction
// channel, downstream decoded-entry channel and the pipeline flush.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_op;
  logic [2:0]       imm_type;
  logic             illegal;
  logic [31:0]      out_instr;
  logic [TAG_W-1:0] out_tag;

  // Environment side: drives instructions in, consumes decoded entries.
  modport master (
    output flush, in_valid, instr, in_tag, out_ready,
    input  in_ready, out_valid, imm_op, imm_type, illegal, out_instr, out_tag
  );

  // Stage side.
  modport slave (
    input  flush, in_valid, instr, in_tag, out_ready,
    output in_ready, out_valid, imm_op, imm_type, illegal, out_instr, out_tag
  );

endinterface

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate-generation stage. Decodes the instruction
// format, produces the XLEN-wide immediate, a format code and an illegal flag,
// and carries the raw instruction plus a sideband tag alongside.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32,
  parameter int unsigned SKID  = 1
) (
  input logic           clk,
  input logic           rst,
  imm_gen_pipe_if.slave bus
);

  localparam logic [4:0] OpLoad    = 5'b00000;
  localparam logic [4:0] OpMiscMem = 5'b00011;
  localparam logic [4:0] OpOpImm   = 5'b00100;
  localparam logic [4:0] OpAuipc   = 5'b00101;
  localparam logic [4:0] OpOpImm32 = 5'b00110;
  localparam logic [4:0] OpStore   = 5'b01000;
  localparam logic [4:0] OpOp      = 5'b01100;
  localparam logic [4:0] OpLui     = 5'b01101;
  localparam logic [4:0] OpOp32    = 5'b01110;
  localparam logic [4:0] OpBranch  = 5'b11000;
  localparam logic [4:0] OpJalr    = 5'b11001;
  localparam logic [4:0] OpJal     = 5'b11011;
  localparam logic [4:0] OpSystem  = 5'b11100;

  localparam logic [2:0] TypeR   = 3'b000;
  localparam logic [2:0] TypeI   = 3'b001;
  localparam logic [2:0] TypeS   = 3'b010;
  localparam logic [2:0] TypeB   = 3'b011;
  localparam logic [2:0] TypeU   = 3'b100;
  localparam logic [2:0] TypeJ   = 3'b101;
  localparam logic [2:0] TypeCsr = 3'b110;
  localparam logic [2:0] TypeIll = 3'b111;

  localparam bit Is64 = (XLEN == 64);
  localparam bit HasSkid = (SKID != 0);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic             illegal;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          dec;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            accept;
  logic            main_free;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

  assign opcode = bus.instr[6:2];
  assign funct3 = bus.instr[14:12];

  // Signed size casts replicate INSTR[31] up to XLEN.
  assign imm_i = XLEN'($signed(bus.instr[31:20]));
  assign imm_s = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
  assign imm_b = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                bus.instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({bus.instr[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                bus.instr[30:21], 1'b0}));
  assign imm_z = XLEN'(bus.instr[19:15]);

  // Format decode of the incoming instruction; anything unrecognised is illegal.
  always_comb begin
    dec.imm     = '0;
    dec.typ     = TypeIll;
    dec.illegal = 1'b1;
    dec.instr   = bus.instr;
    dec.tag     = bus.in_tag;
    if (bus.instr[1:0] == 2'b11) begin
      case (opcode)
        OpLoad, OpOpImm, OpJalr, OpMiscMem: begin
          dec.imm     = imm_i;
          dec.typ     = TypeI;
          dec.illegal = 1'b0;
        end
        OpStore: begin
          dec.imm     = imm_s;
          dec.typ     = TypeS;
          dec.illegal = 1'b0;
        end
        OpBranch: begin
          dec.imm     = imm_b;
          dec.typ     = TypeB;
          dec.illegal = 1'b0;
        end
        OpLui, OpAuipc: begin
          dec.imm     = imm_u;
          dec.typ     = TypeU;
          dec.illegal = 1'b0;
        end
        OpJal: begin
          dec.imm     = imm_j;
          dec.typ     = TypeJ;
          dec.illegal = 1'b0;
        end
        OpOp: begin
          dec.typ     = TypeR;
          dec.illegal = 1'b0;
        end
        OpSystem: begin
          if (funct3 == 3'b100) begin
            dec.typ     = TypeIll;
            dec.illegal = 1'b1;
          end else if (funct3[2]) begin
            dec.imm     = imm_z;
            dec.typ     = TypeCsr;
            dec.illegal = 1'b0;
          end else begin
            dec.imm     = imm_i;
            dec.typ     = TypeI;
            dec.illegal = 1'b0;
          end
        end
        OpOpImm32: begin
          if (Is64) begin
            dec.imm     = imm_i;
            dec.typ     = TypeI;
            dec.illegal = 1'b0;
          end
        end
        OpOp32: begin
          if (Is64) begin
            dec.typ     = TypeR;
            dec.illegal = 1'b0;
          end
        end
        default: begin
          dec.imm     = '0;
          dec.typ     = TypeIll;
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

  assign main_free    = ~main_valid_q | bus.out_ready;
  // Skid mode: ready comes straight from a flop, so it never depends on out_ready.
  assign bus.in_ready = HasSkid ? ~skid_valid_q : main_free;
  assign accept       = bus.in_valid & bus.in_ready;

  // Next-state for the MAIN/SKID entries; strict FIFO order, flush drops both.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) begin
          skid_d = dec;
        end
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_d = dec;
        end
      end
    end else if (accept && HasSkid) begin
      // MAIN is held by backpressure, so the new entry parks in SKID.
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.out_valid = main_valid_q;
  assign bus.imm_op    = main_q.imm;
  assign bus.imm_type  = main_q.typ;
  assign bus.illegal   = main_q.illegal;
  assign bus.out_instr = main_q.instr;
  assign bus.out_tag   = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (XLEN=32 skid, XLEN=64 skid,
// XLEN=32 single register) share the same input stimulus.
module tb_imm_gen_pipe;

  localparam logic [31:0] Addi = 32'hFFF00093;
  localparam logic [31:0] Csri = 32'h300FD073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) busns ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID(1)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SKID(1)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));
  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID(0)) u_dutns (.clk(clk), .rst(rst), .bus(busns));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] tag);
    bus32.in_valid = v; bus32.instr = ins; bus32.in_tag = tag;
    bus64.in_valid = v; bus64.instr = ins; bus64.in_tag = tag;
    busns.in_valid = v; busns.instr = ins; busns.in_tag = tag;
  endtask

  task automatic set_ready(input logic r);
    bus32.out_ready = r;
    bus64.out_ready = r;
    busns.out_ready = r;
  endtask

  task automatic set_flush(input logic f);
    bus32.flush = f;
    bus64.flush = f;
    busns.flush = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    set_flush(1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, Addi, 32'hABCD);
    set_ready(1'b0);
    set_flush(1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (bus32.out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b expected 0", bus32.out_valid); end
    n_checks++; if (bus32.imm_op !== 32'h0) begin n_errors++; $display("FAIL rst_imm: got %h expected 0", bus32.imm_op); end
    n_checks++; if (bus32.imm_type !== 3'b000) begin n_errors++; $display("FAIL rst_type: got %b expected 000", bus32.imm_type); end
    n_checks++; if (bus32.illegal !== 1'b0) begin n_errors++; $display("FAIL rst_illegal: got %b expected 0", bus32.illegal); end
    n_checks++; if (bus32.out_instr !== 32'h0) begin n_errors++; $display("FAIL rst_instr: got %h expected 0", bus32.out_instr); end
    n_checks++; if (bus32.out_tag !== 32'h0) begin n_errors++; $display("FAIL rst_tag: got %h expected 0", bus32.out_tag); end
    n_checks++; if (bus32.in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_in_ready: got %b expected 1", bus32.in_ready); end
    n_checks++; if (bus64.imm_op !== 64'h0) begin n_errors++; $display("FAIL rst_imm64: got %h expected 0", bus64.imm_op); end
  endtask

  task automatic test_decode();
    logic [31:0] v_instr [14];
    logic [31:0] v_imm32 [14];
    logic [2:0]  v_t32   [14];
    logic [63:0] v_imm64 [14];
    logic [2:0]  v_t64   [14];
    v_instr = '{32'hFFF00093, 32'hFE000EE3, 32'h300FD073, 32'h80000037, 32'h0010009B,
                32'hFE20AC23, 32'h008000EF, 32'h002081B3, 32'h002081BB, 32'h00000001,
                32'h00004073, 32'h300020F3, 32'h0000007F, 32'hFFFFF117};
    v_imm32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0000001F, 32'h80000000, 32'h00000000,
                32'hFFFFFFF8, 32'h00000008, 32'h00000000, 32'h00000000, 32'h00000000,
                32'h00000000, 32'h00000300, 32'h00000000, 32'hFFFFF000};
    v_t32   = '{3'd1, 3'd3, 3'd6, 3'd4, 3'd7, 3'd2, 3'd5, 3'd0, 3'd7, 3'd7, 3'd7, 3'd1, 3'd7, 3'd4};
    v_imm64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h1F, 64'hFFFFFFFF80000000, 64'h1,
                64'hFFFFFFFFFFFFFFF8, 64'h8, 64'h0, 64'h0, 64'h0,
                64'h0, 64'h300, 64'h0, 64'hFFFFFFFFFFFFF000};
    v_t64   = '{3'd1, 3'd3, 3'd6, 3'd4, 3'd1, 3'd2, 3'd5, 3'd0, 3'd0, 3'd7, 3'd7, 3'd1, 3'd7, 3'd4};
    do_reset();
    set_ready(1'b1);
    // Back-to-back stream: one vector per cycle, each visible right after its edge.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, v_instr[i], 32'h1000 + i);
      tick();
      n_checks++; if (bus32.out_valid !== 1'b1) begin n_errors++; $display("FAIL dec_valid[%0d]: got %b expected 1", i, bus32.out_valid); end
      n_checks++; if (bus32.imm_op !== v_imm32[i]) begin n_errors++; $display("FAIL dec_imm32[%0d]: got %h expected %h", i, bus32.imm_op, v_imm32[i]); end
      n_checks++; if (bus32.imm_type !== v_t32[i]) begin n_errors++; $display("FAIL dec_type32[%0d]: got %b expected %b", i, bus32.imm_type, v_t32[i]); end
      n_checks++; if (bus32.illegal !== (v_t32[i] == 3'd7)) begin n_errors++; $display("FAIL dec_ill32[%0d]: got %b expected %b", i, bus32.illegal, v_t32[i] == 3'd7); end
      n_checks++; if (bus32.out_instr !== v_instr[i]) begin n_errors++; $display("FAIL dec_instr[%0d]: got %h expected %h", i, bus32.out_instr, v_instr[i]); end
      n_checks++; if (bus32.out_tag !== 32'h1000 + i) begin n_errors++; $display("FAIL dec_tag[%0d]: got %h expected %h", i, bus32.out_tag, 32'h1000 + i); end
      n_checks++; if (bus64.imm_op !== v_imm64[i]) begin n_errors++; $display("FAIL dec_imm64[%0d]: got %h expected %h", i, bus64.imm_op, v_imm64[i]); end
      n_checks++; if (bus64.imm_type !== v_t64[i]) begin n_errors++; $display("FAIL dec_type64[%0d]: got %b expected %b", i, bus64.imm_type, v_t64[i]); end
      n_checks++; if (bus64.illegal !== (v_t64[i] == 3'd7)) begin n_errors++; $display("FAIL dec_ill64[%0d]: got %b expected %b", i, bus64.illegal, v_t64[i] == 3'd7); end
      n_checks++; if (busns.imm_op !== v_imm32[i]) begin n_errors++; $display("FAIL dec_imm_ns[%0d]: got %h expected %h", i, busns.imm_op, v_imm32[i]); end
      n_checks++; if (busns.out_tag !== 32'h1000 + i) begin n_errors++; $display("FAIL dec_tag_ns[%0d]: got %h expected %h", i, busns.out_tag, 32'h1000 + i); end
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (bus32.out_valid !== 1'b0) begin n_errors++; $display("FAIL dec_drain: got %b expected 0", bus32.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic acc3;
    acc3 = 1'b0;
    do_reset();
    set_ready(1'b0);
    drive(1'b1, Addi, 32'd1);
    #1;
    n_checks++; if (bus32.in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready1: got %b expected 1", bus32.in_ready); end
    tick();
    drive(1'b1, Addi, 32'd2);
    #1;
    n_checks++; if (bus32.in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready2: got %b expected 1", bus32.in_ready); end
    tick();
    drive(1'b1, Addi, 32'd3);
    #1;
    n_checks++; if (bus32.in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready3: got %b expected 0", bus32.in_ready); end
    n_checks++; if (bus32.out_tag !== 32'd1) begin n_errors++; $display("FAIL bp_head: got %0d expected 1", bus32.out_tag); end
    tick();
    n_checks++; if (bus32.out_tag !== 32'd1) begin n_errors++; $display("FAIL bp_hold_tag: got %0d expected 1", bus32.out_tag); end
    n_checks++; if (bus32.imm_op !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL bp_hold_imm: got %h expected ffffffff", bus32.imm_op); end
    n_checks++; if (bus32.in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_still_full: got %b expected 0", bus32.in_ready); end
    set_ready(1'b1);
    for (int k = 1; k <= 3; k++) begin
      n_checks++; if (bus32.out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", k, bus32.out_valid); end
      n_checks++; if (bus32.out_tag !== 32'(k)) begin n_errors++; $display("FAIL bp_order[%0d]: got %0d expected %0d", k, bus32.out_tag, k); end
      if (bus32.in_valid && bus32.in_ready) acc3 = 1'b1;
      tick();
      if (acc3) drive(1'b0, 32'h0, 32'h0);
    end
    n_checks++; if (acc3 !== 1'b1) begin n_errors++; $display("FAIL bp_tag3_accepted: got %b expected 1", acc3); end
    n_checks++; if (bus32.out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty: got %b expected 0", bus32.out_valid); end
  endtask

  task automatic test_single_reg();
    do_reset();
    set_ready(1'b0);
    drive(1'b1, Addi, 32'd1);
    tick();
    drive(1'b1, Csri, 32'd2);
    #1;
    n_checks++; if (busns.in_ready !== 1'b0) begin n_errors++; $display("FAIL ns_ready_held: got %b expected 0", busns.in_ready); end
    set_ready(1'b1);
    #1;
    n_checks++; if (busns.in_ready !== 1'b1) begin n_errors++; $display("FAIL ns_ready_drain: got %b expected 1", busns.in_ready); end
    tick();
    n_checks++; if (busns.out_tag !== 32'd2) begin n_errors++; $display("FAIL ns_next_tag: got %0d expected 2", busns.out_tag); end
    n_checks++; if (busns.imm_op !== 32'h1F) begin n_errors++; $display("FAIL ns_next_imm: got %h expected 1f", busns.imm_op); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (busns.out_valid !== 1'b0) begin n_errors++; $display("FAIL ns_empty: got %b expected 0", busns.out_valid); end
  endtask

  task automatic test_flush();
    // Both entries full, flush with a presented input.
    do_reset();
    set_ready(1'b0);
    drive(1'b1, Addi, 32'd1);
    tick();
    drive(1'b1, Addi, 32'd2);
    tick();
    drive(1'b1, Addi, 32'd9);
    set_flush(1'b1);
    tick();
    set_flush(1'b0);
    drive(1'b0, 32'h0, 32'h0);
    n_checks++; if (bus32.out_valid !== 1'b0) begin n_errors++; $display("FAIL fl_valid: got %b expected 0", bus32.out_valid); end
    n_checks++; if (bus32.in_ready !== 1'b1) begin n_errors++; $display("FAIL fl_ready: got %b expected 1", bus32.in_ready); end
    set_ready(1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (bus32.out_valid !== 1'b0) begin n_errors++; $display("FAIL fl_ghost[%0d]: got %b expected 0", k, bus32.out_valid); end
    end
    // Skid empty: the flush-cycle input is accepted and must still be discarded.
    set_ready(1'b0);
    drive(1'b1, Addi, 32'd1);
    tick();
    drive(1'b1, Addi, 32'd9);
    set_flush(1'b1);
    tick();
    set_flush(1'b0);
    drive(1'b0, 32'h0, 32'h0);
    set_ready(1'b1);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (bus32.out_valid !== 1'b0) begin n_errors++; $display("FAIL fl_discard[%0d]: got %b expected 0", k, bus32.out_valid); end
      tick();
    end
    // Single-register mode, accept and flush in the same cycle.
    drive(1'b1, Addi, 32'd9);
    set_flush(1'b1);
    tick();
    set_flush(1'b0);
    drive(1'b0, 32'h0, 32'h0);
    n_checks++; if (busns.out_valid !== 1'b0) begin n_errors++; $display("FAIL fl_ns: got %b expected 0", busns.out_valid); end
    drive(1'b1, Csri, 32'h55);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_checks++; if (bus32.out_tag !== 32'h55 || bus32.out_valid !== 1'b1) begin n_errors++; $display("FAIL fl_resume: got valid %b tag %h expected valid 1 tag 55", bus32.out_valid, bus32.out_tag); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ready(1'b0);
    drive(1'b1, Csri, 32'd1);
    tick();
    drive(1'b1, Csri, 32'd2);
    tick();
    drive(1'b1, Csri, 32'd3);
    rst = 1'b1;
    set_flush(1'b1);
    tick();
    set_flush(1'b0);
    n_checks++; if (bus32.out_valid !== 1'b0) begin n_errors++; $display("FAIL mr_valid: got %b expected 0", bus32.out_valid); end
    n_checks++; if (bus32.imm_op !== 32'h0) begin n_errors++; $display("FAIL mr_imm: got %h expected 0", bus32.imm_op); end
    n_checks++; if (bus32.imm_type !== 3'b000) begin n_errors++; $display("FAIL mr_type: got %b expected 000", bus32.imm_type); end
    n_checks++; if (bus32.out_instr !== 32'h0) begin n_errors++; $display("FAIL mr_instr: got %h expected 0", bus32.out_instr); end
    n_checks++; if (bus32.out_tag !== 32'h0) begin n_errors++; $display("FAIL mr_tag: got %h expected 0", bus32.out_tag); end
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin n_errors++; $display("FAIL mr_idle: got ready %b valid %b expected 1 0", bus32.in_ready, bus32.out_valid); end
    set_ready(1'b1);
    drive(1'b1, Csri, 32'd4);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    n_checks++; if (bus32.out_tag !== 32'd4) begin n_errors++; $display("FAIL mr_resume_tag: got %0d expected 4", bus32.out_tag); end
    n_checks++; if (bus32.imm_type !== 3'b110) begin n_errors++; $display("FAIL mr_resume_type: got %b expected 110", bus32.imm_type); end
    tick();
    n_checks++; if (bus32.out_valid !== 1'b0) begin n_errors++; $display("FAIL mr_no_stale: got %b expected 0", bus32.out_valid); end
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0);
    set_ready(1'b0);
    set_flush(1'b0);
    test_reset();
    test_decode();
    test_back_to_back();
    test_single_reg();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
